// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode-side signal bundle for fetch_unit
interface fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic [CNT_W-1:0]   buf_count;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, buf_count,
    input  imem_data, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, buf_count,
    output imem_data, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch front end with tagged FIFO toward decode
// Optional FETCH_PERF_EN adds saturating transfer/redirect counters.
module fetch_unit #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 32,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetch,
  output logic [15:0]  perf_flush
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]    fpc;
  logic [PC_W-1:0]    tag_pc;
  logic               inflight;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic               issue;
  logic               push;
  logic               pop;
  logic [CNT_W:0]     credit_used;

  // Reserving a slot for the outstanding read keeps the buffer from ever overflowing.
  always_comb begin
    credit_used = {1'b0, count} + (CNT_W+1)'(inflight);
    issue       = !rst && !bus.redirect && (credit_used < (CNT_W+1)'(DEPTH));
    push        = inflight && !bus.redirect;
    pop         = bus.id_valid && bus.id_ready;
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fpc;
  assign bus.id_valid  = (count != '0);
  assign bus.id_instr  = instr_q[rd_ptr];
  assign bus.id_pc     = pc_q[rd_ptr];
  assign bus.buf_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= PC_W'(RESET_PC);
      tag_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (bus.redirect) begin
      fpc      <= bus.redirect_pc;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (issue) begin
        fpc    <= fpc + PC_W'(PC_STEP);
        tag_pc <= fpc;
      end
      inflight <= issue;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_q[wr_ptr] <= bus.imem_data;
      pc_q[wr_ptr]    <= tag_pc;
    end
  end

`ifdef FETCH_PERF_EN
  // A transfer coinciding with a redirect still counts: ID saw the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= '0;
      perf_flush <= '0;
    end else begin
      if (pop && (perf_fetch != '1))          perf_fetch <= perf_fetch + 32'd1;
      if (bus.redirect && (perf_flush != '1)) perf_flush <= perf_flush + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit (default and wrapping reset PC)
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  fetch_unit_if #(.PC_W(8), .INSTR_W(32), .DEPTH(4)) bus  ();
  fetch_unit_if #(.PC_W(8), .INSTR_W(32), .DEPTH(4)) wbus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [15:0] perf_flush;
  logic [31:0] w_perf_fetch;
  logic [15:0] w_perf_flush;
`endif

  fetch_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_flush (perf_flush)
`endif
  );

  fetch_unit #(.RESET_PC(8'hFE)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch (w_perf_fetch),
    .perf_flush (w_perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return {16'hBEEF, ~a, a};
  endfunction

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_req)  bus.imem_data  <= word_of(bus.imem_addr);
    if (wbus.imem_req) wbus.imem_data <= word_of(wbus.imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] e;
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus.id_ready     = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    wbus.id_ready    = 1'b1;
    wbus.redirect    = 1'b0;
    wbus.redirect_pc = '0;
    repeat (3) tick;

    check("rst_req",   bus.imem_req,  0);
    check("rst_valid", bus.id_valid,  0);
    check("rst_count", bus.buf_count, 0);

    // sequential fetch, one instruction per cycle
    rst = 1'b0;
    #1;
    check("first_req",  bus.imem_req,  1);
    check("first_addr", bus.imem_addr, 8'h00);
    tick;
    check("lat1_valid", bus.id_valid, 0);
    tick;
    for (int i = 0; i < 6; i++) begin
      check("seq_valid", bus.id_valid, 1);
      check("seq_pc",    bus.id_pc,    i);
      check("seq_instr", bus.id_instr, word_of(8'(i)));
      if (i < 4) begin
        e = 8'hFE + 8'(i);
        check("wrap_pc",    wbus.id_pc,    e);
        check("wrap_instr", wbus.id_instr, word_of(e));
      end
      tick;
    end

    // stall: buffer fills, head stays put, fetch stops
    bus.id_ready = 1'b0;
    repeat (10) begin
      tick;
      check("stall_pc", bus.id_pc, 6);
    end
    check("full_count", bus.buf_count, 4);
    check("full_req",   bus.imem_req,  0);
    bus.id_ready = 1'b1;
    for (int i = 6; i < 14; i++) begin
      check("drain_valid", bus.id_valid, 1);
      check("drain_pc",    bus.id_pc,    i);
      tick;
    end

    // redirect with 3 buffered and 1 in flight
    bus.id_ready = 1'b0;
    for (int k = 0; k < 10 && bus.buf_count != 3; k++) tick;
    check("pre_redir_count", bus.buf_count, 3);
    check("pre_redir_req",   bus.imem_req,  0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    #1;
    check("redir_req", bus.imem_req, 0);
    tick;
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    check("redir_count", bus.buf_count, 0);
    check("redir_v0",    bus.id_valid,  0);
    tick;
    check("redir_v1", bus.id_valid, 0);
    tick;
    check("redir_valid", bus.id_valid, 1);
    check("redir_pc0",   bus.id_pc,    8'h40);
    check("redir_instr", bus.id_instr, word_of(8'h40));
    tick;
    check("redir_pc1", bus.id_pc, 8'h41);
    tick;
    check("redir_pc2", bus.id_pc, 8'h42);

    // reset mid-stream with a full buffer
    bus.id_ready = 1'b0;
    for (int k = 0; k < 10 && bus.buf_count != 4; k++) tick;
    check("prerst_count", bus.buf_count, 4);
    rst = 1'b1;
    #1;
    check("midrst_req", bus.imem_req, 0);
    tick;
    check("midrst_valid", bus.id_valid,  0);
    check("midrst_count", bus.buf_count, 0);
    rst = 1'b0;
    bus.id_ready = 1'b1;
    tick;
    check("rerst_v0", bus.id_valid, 0);
    tick;
    check("rerst_valid", bus.id_valid, 1);
    check("rerst_pc",    bus.id_pc,    0);
`ifdef FETCH_PERF_EN
    check("perf_fetch_rst", perf_fetch, 0);
    check("perf_flush_rst", perf_flush, 0);
`endif

    // 20 transfers, then 3 back-to-back redirects; last target wins
    repeat (20) tick;
    check("run_pc", bus.id_pc, 20);
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h10;
    tick;
    bus.redirect_pc = 8'h20;
    tick;
    bus.redirect_pc = 8'h30;
    tick;
    bus.redirect = 1'b0;
    tick;
    check("b2b_v0", bus.id_valid, 0);
    tick;
    check("b2b_valid", bus.id_valid, 1);
    check("b2b_pc",    bus.id_pc,    8'h30);
`ifdef FETCH_PERF_EN
    check("perf_fetch", perf_fetch, 20);
    check("perf_flush", perf_flush, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
